alu_64: RTL and testbench



---
 rtl/alu_64_pkg.sv | 11 +
 rtl/alu_64_addsub.sv | 20 ++
 rtl/alu_64.sv | 65 ++++++
 tb/tb_alu_64.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_64_pkg.sv
// Shared constants for the Y86-64 execute-stage ALU: datapath width and opcode encodings.
package alu_64_pkg;

  localparam int WORD_W = 64;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

endpackage

// File: rtl/alu_64_addsub.sv
// 64-bit two's-complement adder/subtractor with signed overflow.
// Subtraction is computed as a + ~b + 1; the carry-out is discarded.
module alu_64_addsub
  import alu_64_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              sub,
  output logic [WORD_W-1:0] sum,
  output logic              ovf
);

  logic [WORD_W-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + {{(WORD_W-1){1'b0}}, sub};
  // Operands of equal sign (after inversion) producing a result of the other sign.
  assign ovf   = (a[WORD_W-1] == b_eff[WORD_W-1]) && (sum[WORD_W-1] != a[WORD_W-1]);

endmodule

// File: rtl/alu_64.sv
// Combinational 64-bit ALU for the execute stage with a registered condition-code
// holding register (zero/sign/overflow) updated when cc_en is set.
module alu_64
  import alu_64_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        Ctrl,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  input  logic              cc_en,
  output logic [WORD_W-1:0] O,
  output logic              OF,
  output logic              zf_q,
  output logic              sf_q,
  output logic              of_q
);

  logic [WORD_W-1:0] arith_sum;
  logic              arith_ovf;
  logic              zf;
  logic              sf;

  alu_64_addsub u_addsub (
    .a   (A),
    .b   (B),
    .sub (Ctrl == ALU_SUB),
    .sum (arith_sum),
    .ovf (arith_ovf)
  );

  always_comb begin
    O  = '0;
    OF = 1'b0;
    case (Ctrl)
      ALU_ADD,
      ALU_SUB: begin
        O  = arith_sum;
        OF = arith_ovf;
      end
      ALU_AND: O = A & B;
      ALU_XOR: O = A ^ B;
      default: begin
        O  = '0;
        OF = 1'b0;
      end
    endcase
  end

  assign zf = (O == '0);
  assign sf = O[WORD_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b0;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else if (cc_en) begin
      zf_q <= zf;
      sf_q <= sf;
      of_q <= OF;
    end
  end

endmodule

// File: tb/tb_alu_64.sv
// Directed self-checking bench for alu_64: arithmetic/logic results, overflow
// boundaries, CC latching with enable, and asynchronous reset behaviour.
module tb_alu_64;

  logic        clk;
  logic        rst_n;
  logic [1:0]  Ctrl;
  logic [63:0] A;
  logic [63:0] B;
  logic        cc_en;
  logic [63:0] O;
  logic        OF;
  logic        zf_q;
  logic        sf_q;
  logic        of_q;

  int vec_cnt;
  int err_cnt;

  alu_64 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Ctrl  (Ctrl),
    .A     (A),
    .B     (B),
    .cc_en (cc_en),
    .O     (O),
    .OF    (OF),
    .zf_q  (zf_q),
    .sf_q  (sf_q),
    .of_q  (of_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive operands on the falling edge, then let the combinational path settle.
  task automatic apply(input logic [1:0] c, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    Ctrl = c;
    A    = a;
    B    = b;
    #1;
  endtask

  task automatic test_reset();
    vec_cnt++;
    if ({zf_q, sf_q, of_q} !== 3'b000) begin
      err_cnt++;
      $display("FAIL reset_flags: got %b expected 000", {zf_q, sf_q, of_q});
    end
  endtask

  task automatic test_add();
    apply(2'b00, 64'd5, 64'd3);
    vec_cnt++;
    if (O !== 64'd8 || OF !== 1'b0) begin
      err_cnt++;
      $display("FAIL add_5_3: got O=%h OF=%b expected O=%h OF=0", O, OF, 64'd8);
    end
    apply(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    vec_cnt++;
    if (O !== 64'h8000_0000_0000_0000 || OF !== 1'b1) begin
      err_cnt++;
      $display("FAIL add_max_pos: got O=%h OF=%b expected O=8000000000000000 OF=1", O, OF);
    end
    apply(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    vec_cnt++;
    if (O !== 64'd0 || OF !== 1'b0) begin
      err_cnt++;
      $display("FAIL add_m1_p1: got O=%h OF=%b expected O=0 OF=0", O, OF);
    end
    apply(2'b00, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    vec_cnt++;
    if (O !== 64'd0 || OF !== 1'b1) begin
      err_cnt++;
      $display("FAIL add_min_min: got O=%h OF=%b expected O=0 OF=1", O, OF);
    end
  endtask

  task automatic test_sub();
    apply(2'b01, 64'd3, 64'd5);
    vec_cnt++;
    if (O !== 64'hFFFF_FFFF_FFFF_FFFE || OF !== 1'b0) begin
      err_cnt++;
      $display("FAIL sub_3_5: got O=%h OF=%b expected O=fffffffffffffffe OF=0", O, OF);
    end
    apply(2'b01, 64'h8000_0000_0000_0000, 64'd1);
    vec_cnt++;
    if (O !== 64'h7FFF_FFFF_FFFF_FFFF || OF !== 1'b1) begin
      err_cnt++;
      $display("FAIL sub_min_1: got O=%h OF=%b expected O=7fffffffffffffff OF=1", O, OF);
    end
    apply(2'b01, 64'd0, 64'h8000_0000_0000_0000);
    vec_cnt++;
    if (O !== 64'h8000_0000_0000_0000 || OF !== 1'b1) begin
      err_cnt++;
      $display("FAIL sub_0_min: got O=%h OF=%b expected O=8000000000000000 OF=1", O, OF);
    end
    apply(2'b01, 64'd100, 64'd58);
    vec_cnt++;
    if (O !== 64'd42 || OF !== 1'b0) begin
      err_cnt++;
      $display("FAIL sub_100_58: got O=%h OF=%b expected O=%h OF=0", O, OF, 64'd42);
    end
  endtask

  task automatic test_logic();
    apply(2'b10, 64'hF0F0, 64'hFF00);
    vec_cnt++;
    if (O !== 64'hF000 || OF !== 1'b0) begin
      err_cnt++;
      $display("FAIL and_f0f0: got O=%h OF=%b expected O=f000 OF=0", O, OF);
    end
    apply(2'b11, 64'hF0F0, 64'hFF00);
    vec_cnt++;
    if (O !== 64'h0FF0 || OF !== 1'b0) begin
      err_cnt++;
      $display("FAIL xor_f0f0: got O=%h OF=%b expected O=0ff0 OF=0", O, OF);
    end
    // Overflowing operands must not raise OF for logic ops.
    apply(2'b10, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF);
    vec_cnt++;
    if (O !== 64'h7FFF_FFFF_FFFF_FFFF || OF !== 1'b0) begin
      err_cnt++;
      $display("FAIL and_nooverflow: got O=%h OF=%b expected O=7fffffffffffffff OF=0", O, OF);
    end
  endtask

  task automatic test_stack();
    apply(2'b00, 64'hFFFF_FFFF_FFFF_FFF8, 64'h100);
    vec_cnt++;
    if (O !== 64'hF8) begin
      err_cnt++;
      $display("FAIL stack_push: got O=%h expected O=f8", O);
    end
    apply(2'b00, 64'd8, 64'h100);
    vec_cnt++;
    if (O !== 64'h108) begin
      err_cnt++;
      $display("FAIL stack_pop: got O=%h expected O=108", O);
    end
  endtask

  task automatic test_cc();
    apply(2'b01, 64'd7, 64'd7);
    cc_en = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if ({zf_q, sf_q, of_q} !== 3'b100) begin
      err_cnt++;
      $display("FAIL cc_equal: got zsf=%b expected 100", {zf_q, sf_q, of_q});
    end
    apply(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    cc_en = 1'b0;
    @(posedge clk); #1;
    vec_cnt++;
    if ({zf_q, sf_q, of_q} !== 3'b100) begin
      err_cnt++;
      $display("FAIL cc_hold: got zsf=%b expected 100", {zf_q, sf_q, of_q});
    end
    @(negedge clk);
    cc_en = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if ({zf_q, sf_q, of_q} !== 3'b010) begin
      err_cnt++;
      $display("FAIL cc_negative: got zsf=%b expected 010", {zf_q, sf_q, of_q});
    end
    apply(2'b01, 64'h8000_0000_0000_0000, 64'd1);
    @(posedge clk); #1;
    vec_cnt++;
    if ({zf_q, sf_q, of_q} !== 3'b001) begin
      err_cnt++;
      $display("FAIL cc_overflow: got zsf=%b expected 001", {zf_q, sf_q, of_q});
    end
    apply(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    @(posedge clk); #1;
    vec_cnt++;
    if ({zf_q, sf_q, of_q} !== 3'b100) begin
      err_cnt++;
      $display("FAIL cc_wrap_zero: got zsf=%b expected 100", {zf_q, sf_q, of_q});
    end
    @(negedge clk);
    cc_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply(2'b01, 64'd7, 64'd7);
    cc_en = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if (zf_q !== 1'b1) begin
      err_cnt++;
      $display("FAIL rst_setup: got zf_q=%b expected 1", zf_q);
    end
    // Assert reset mid-cycle with cc_en still high: flags clear without an edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({zf_q, sf_q, of_q} !== 3'b000) begin
      err_cnt++;
      $display("FAIL rst_async: got zsf=%b expected 000", {zf_q, sf_q, of_q});
    end
    Ctrl = 2'b00;
    A    = 64'd1;
    B    = 64'd2;
    #1;
    vec_cnt++;
    if (O !== 64'd3 || OF !== 1'b0) begin
      err_cnt++;
      $display("FAIL rst_o_tracks: got O=%h OF=%b expected O=3 OF=0", O, OF);
    end
    Ctrl = 2'b01;
    A    = 64'd7;
    B    = 64'd7;
    @(posedge clk); #1;
    vec_cnt++;
    if ({zf_q, sf_q, of_q} !== 3'b000) begin
      err_cnt++;
      $display("FAIL rst_beats_en: got zsf=%b expected 000", {zf_q, sf_q, of_q});
    end
    @(negedge clk);
    cc_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if ({zf_q, sf_q, of_q} !== 3'b000) begin
      err_cnt++;
      $display("FAIL rst_release_hold: got zsf=%b expected 000", {zf_q, sf_q, of_q});
    end
    @(negedge clk);
    cc_en = 1'b1;
    @(posedge clk); #1;
    vec_cnt++;
    if ({zf_q, sf_q, of_q} !== 3'b100) begin
      err_cnt++;
      $display("FAIL rst_first_update: got zsf=%b expected 100", {zf_q, sf_q, of_q});
    end
    @(negedge clk);
    cc_en = 1'b0;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    rst_n   = 1'b0;
    cc_en   = 1'b0;
    Ctrl    = 2'b00;
    A       = '0;
    B       = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_add();
    test_sub();
    test_logic();
    test_stack();
    test_cc();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
